drive_arbiter: RTL and testbench
================================

// Module: drive_arbiter
// PURPOSE
//  Owns motor drive commands DriveA/DriveB to the PWM generator. Sequences rover run/stop.
//  Arbitrates between three sources: line-follower commands, obstacle hold, overcurrent fault.
//  Sits between the movement state machine outputs and the PWM generator in the drive system.
// PARAMETERS
//  DEBOUNCE     16      consecutive cycles Obstacle must hold a level before it is accepted
//  COOL_CYCLES  1000    cycles spent in COOL after fault clear before returning to IDLE
//  RAMP_TICKS   250000  cycles per one-step drive change (used only with DRIVE_RAMP_EN)
// PORTS
//  CLK       in   1  system clock, rising edge
//  RSTn      in   1  asynchronous active-low reset
//  Start     in   1  level; sampled high in IDLE -> RUN
//  Stop      in   1  level; sampled high in RUN/HOLD -> IDLE
//  LfA       in   2  line-follower request for motor A (0 off, 1 low, 2 high, 3 clamped to 2)
//  LfB       in   2  line-follower request for motor B (same encoding)
//  Obstacle  in   1  ultrasonic obstacle-near flag, raw level
//  OcA       in   1  overcurrent comparator, motor A
//  OcB       in   1  overcurrent comparator, motor B
//  FaultClr  in   1  level; requests exit from FAULT
//  DriveA    out  2  drive level to PWM A
//  DriveB    out  2  drive level to PWM B
//  State     out  3  current arbiter state (package encoding)
//  FaultFlag out  1  high in FAULT and COOL
// BEHAVIOUR
//  Reset: State=IDLE, DriveA=DriveB=0, FaultFlag=0, debounce/cool/ramp counters=0, ObsOk=0.
//  All outputs registered; requests appear on DriveA/B one cycle after sampling.
//  Without ramping, the arbiter adds exactly one cycle of latency.
//  Obstacle debounce: ObsOk toggles only after DEBOUNCE consecutive cycles at the new level.
//   Any opposite sample restarts the count.
//  States:
//   IDLE : target 0/0. Start=1 -> RUN.
//   RUN  : target=clamp(LfA)/clamp(LfB). Stop -> IDLE. Else ObsOk=1 -> HOLD.
//   HOLD : target 0/0. Stop -> IDLE. Else ObsOk=0 -> RUN. Start is ignored.
//   FAULT: DriveA=DriveB=0 forced. Exit to COOL when FaultClr=1 and OcA=OcB=0.
//   COOL : target 0/0. Counter counts COOL_CYCLES, then -> IDLE.
//          OcA|OcB during COOL -> FAULT and the counter is cleared.
//  Priority in the same cycle: OcA|OcB > Stop > ObsOk > Start.
//   OcA|OcB from any state -> FAULT on that edge.
//   DriveA/B=0 and FaultFlag=1 are registered on the same edge (no ramp).
//  Stop and Obstacle together in RUN -> IDLE.
//  After Stop, a new Start is required. A Start held high re-enters RUN the next cycle after IDLE.
//  Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous).
// CONFIGURATION
//  DRIVE_RAMP_EN defined:
//   DriveA/B move toward target by at most +/-1 per RAMP_TICKS cycles.
//   A shared tick counter free-runs while any output != target; it resets to 0 when both match.
//   FAULT still forces 0 immediately.
//  DRIVE_RAMP_EN undefined: DriveA/B <= target every cycle. RAMP_TICKS is unused.
// STRUCTURE
//  Package drive_pkg holds:
//   - state encodings: IDLE=0, RUN=1, HOLD=2, FAULT=3, COOL=4
//   - drive constants: DRV_OFF=0, DRV_LOW=1, DRV_HIGH=2
//   - function clamp_drive(2b) -> 2b
//  Sub-module sig_debounce (#DEBOUNCE): CLK, RSTn, In -> Out; instanced once for Obstacle.
//  Counter widths are $clog2(param+1).
// TESTING
//  Bench parameters: DEBOUNCE=4, COOL_CYCLES=8, RAMP_TICKS=3; macro off unless noted.
//  1. Start=1 pulse, LfA=2, LfB=1 -> State=RUN; next cycle DriveA=2, DriveB=1; LfA=3 -> DriveA=2.
//  2. In RUN, Obstacle high 3 cycles then low -> no HOLD.
//     Obstacle high 4 cycles -> HOLD, Drive=0/0.
//     Obstacle low 4 cycles -> RUN, Drive follows Lf.
//  3. In RUN with Drive=2/2, OcB=1 one cycle -> next edge FAULT, Drive=0/0, FaultFlag=1.
//     FaultClr=1 with OcB=0 -> COOL for 8 cycles -> IDLE, FaultFlag=0.
//  4. In COOL at cycle 5, OcA=1 -> FAULT.
//     Same cycle OcA=1, Stop=1, Start=1 from RUN -> FAULT.
//  5. DRIVE_RAMP_EN: RUN with LfA=2 from 0 -> DriveA=1 after 3 cycles, 2 after 6.
//     OcA then -> DriveA=0 next edge.
//  6. RSTn low mid-RUN with Drive=2/2 -> Drive=0/0, State=IDLE immediately; stays IDLE after release until Start.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared types and helpers for the drive arbiter.
// Holds the arbiter state encoding, drive level constants and the request clamp.
package drive_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      HOLD  = 3'd2,
      FAULT = 3'd3,
      COOL  = 3'd4
   } arb_state_t;

   localparam logic [1:0] DRV_OFF  = 2'd0;
   localparam logic [1:0] DRV_LOW  = 2'd1;
   localparam logic [1:0] DRV_HIGH = 2'd2;

   // Request code 3 has no meaning at the PWM side; it is treated as full drive.
   function automatic logic [1:0] clamp_drive(input logic [1:0] req);
      if (req > DRV_HIGH) begin
         return DRV_HIGH;
      end
      return req;
   endfunction

endpackage

// File: rtl/drive_arbiter_sig_debounce.sv
// Level debouncer: Out follows In only after In has held its new level for
// DEBOUNCE consecutive clock cycles. Any sample at the old level restarts the count.
module sig_debounce #(
   parameter int unsigned DEBOUNCE = 16
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic In,
   output logic Out
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

   logic [CNT_W-1:0] cnt;

   // Count cycles at the opposite level; accept the new level on the DEBOUNCE-th one.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt <= '0;
         Out <= 1'b0;
      end else if (In == Out) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
         cnt <= '0;
         Out <= In;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/drive_arbiter.sv
// Motor drive arbiter: owns DriveA/DriveB towards the PWM generator and sequences
// run/stop, obstacle hold and overcurrent fault recovery.
// Build option: define DRIVE_RAMP_EN to slew the drive outputs by one level per
// RAMP_TICKS cycles instead of jumping straight to the target.
// There is no valid/ready handshake here: every input is a level sampled each cycle.
module drive_arbiter
   import drive_pkg::*;
#(
   parameter int unsigned DEBOUNCE    = 16,
   parameter int unsigned COOL_CYCLES = 1000,
   parameter int unsigned RAMP_TICKS  = 250000
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       Start,
   input  logic       Stop,
   input  logic [1:0] LfA,
   input  logic [1:0] LfB,
   input  logic       Obstacle,
   input  logic       OcA,
   input  logic       OcB,
   input  logic       FaultClr,
   output logic [1:0] DriveA,
   output logic [1:0] DriveB,
   output logic [2:0] State,
   output logic       FaultFlag
);

   localparam int unsigned COOL_W = $clog2(COOL_CYCLES + 1);

   // Zero-valued parameters would make the counter compares meaningless.
   if (DEBOUNCE == 0 || COOL_CYCLES == 0 || RAMP_TICKS == 0) begin : g_param_check
      $error("drive_arbiter: DEBOUNCE, COOL_CYCLES and RAMP_TICKS must be nonzero");
   end

   arb_state_t        state_q, state_d;
   logic              obs_ok;
   logic              oc_any;
   logic [COOL_W-1:0] cool_cnt;
   logic              cool_done;
   logic [1:0]        tgt_a, tgt_b;
   logic              force_zero;
   logic              fault_d;
   logic [1:0]        drv_a_q, drv_b_q;
   logic              fault_q;

   sig_debounce #(.DEBOUNCE(DEBOUNCE)) u_obs_debounce (
      .CLK  (CLK),
      .RSTn (RSTn),
      .In   (Obstacle),
      .Out  (obs_ok)
   );

   assign oc_any    = OcA | OcB;
   assign cool_done = (cool_cnt == COOL_W'(COOL_CYCLES - 1));

   // State register.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; overcurrent wins over everything, then Stop, then obstacle, then Start.
   always_comb begin
      state_d = state_q;
      if (oc_any) begin
         state_d = FAULT;
      end else begin
         case (state_q)
            IDLE:    if (Start) state_d = RUN;
            RUN:     if (Stop) state_d = IDLE;
                     else if (obs_ok) state_d = HOLD;
            HOLD:    if (Stop) state_d = IDLE;
                     else if (!obs_ok) state_d = RUN;
            FAULT:   if (FaultClr) state_d = COOL;
            COOL:    if (cool_done) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Drive targets and the next fault flag, derived from the current/next state.
   always_comb begin
      tgt_a      = DRV_OFF;
      tgt_b      = DRV_OFF;
      if (state_q == RUN) begin
         tgt_a = clamp_drive(LfA);
         tgt_b = clamp_drive(LfB);
      end
      force_zero = (state_d == FAULT) || (state_q == FAULT);
      fault_d    = (state_d == FAULT) || (state_d == COOL);
   end

   // Cool-down counter: runs only while staying in COOL, cleared on any exit.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cool_cnt <= '0;
      end else if (state_q == COOL && state_d == COOL) begin
         cool_cnt <= cool_cnt + 1'b1;
      end else begin
         cool_cnt <= '0;
      end
   end

   // Fault flag is registered on the same edge that enters FAULT.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end

`ifdef DRIVE_RAMP_EN
   localparam int unsigned RAMP_W = $clog2(RAMP_TICKS + 1);

   logic [RAMP_W-1:0] ramp_cnt;

   function automatic logic [1:0] step_toward(input logic [1:0] cur, input logic [1:0] tgt);
      if (cur < tgt) return cur + 2'd1;
      if (cur > tgt) return cur - 2'd1;
      return cur;
   endfunction

   // Slew both drives one level per RAMP_TICKS; the shared tick idles at 0 when settled.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         drv_a_q  <= DRV_OFF;
         drv_b_q  <= DRV_OFF;
         ramp_cnt <= '0;
      end else if (force_zero) begin
         drv_a_q  <= DRV_OFF;
         drv_b_q  <= DRV_OFF;
         ramp_cnt <= '0;
      end else if (drv_a_q == tgt_a && drv_b_q == tgt_b) begin
         ramp_cnt <= '0;
      end else if (ramp_cnt == RAMP_W'(RAMP_TICKS - 1)) begin
         drv_a_q  <= step_toward(drv_a_q, tgt_a);
         drv_b_q  <= step_toward(drv_b_q, tgt_b);
         ramp_cnt <= '0;
      end else begin
         ramp_cnt <= ramp_cnt + 1'b1;
      end
   end
`else
   // Drives take the target every cycle; a fault forces them off on the entry edge.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         drv_a_q <= DRV_OFF;
         drv_b_q <= DRV_OFF;
      end else if (force_zero) begin
         drv_a_q <= DRV_OFF;
         drv_b_q <= DRV_OFF;
      end else begin
         drv_a_q <= tgt_a;
         drv_b_q <= tgt_b;
      end
   end
`endif

   assign DriveA    = drv_a_q;
   assign DriveB    = drv_b_q;
   assign State     = state_q;
   assign FaultFlag = fault_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// Bench for drive_arbiter with small parameters (DEBOUNCE=4, COOL_CYCLES=8, RAMP_TICKS=3).
// Define DRIVE_RAMP_EN to exercise the ramped drive build.
module tb_drive_arbiter;

   localparam int DEBOUNCE    = 4;
   localparam int COOL_CYCLES = 8;
   localparam int RAMP_TICKS  = 3;
`ifdef DRIVE_RAMP_EN
   localparam int SETTLE = 2 * RAMP_TICKS + 1;
`else
   localparam int SETTLE = 1;
`endif

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_HOLD  = 3'd2;
   localparam logic [2:0] S_FAULT = 3'd3;
   localparam logic [2:0] S_COOL  = 3'd4;

   logic       CLK;
   logic       RSTn;
   logic       Start, Stop, Obstacle, OcA, OcB, FaultClr;
   logic [1:0] LfA, LfB;
   logic [1:0] DriveA, DriveB;
   logic [2:0] State;
   logic       FaultFlag;

   int checks;
   int errors;
   logic [3:0] exp_q[$];

   drive_arbiter #(
      .DEBOUNCE    (DEBOUNCE),
      .COOL_CYCLES (COOL_CYCLES),
      .RAMP_TICKS  (RAMP_TICKS)
   ) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .Start     (Start),
      .Stop      (Stop),
      .LfA       (LfA),
      .LfB       (LfB),
      .Obstacle  (Obstacle),
      .OcA       (OcA),
      .OcB       (OcB),
      .FaultClr  (FaultClr),
      .DriveA    (DriveA),
      .DriveB    (DriveB),
      .State     (State),
      .FaultFlag (FaultFlag)
   );

   // Clock / reset block
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [1:0] ref_clamp(input logic [1:0] r);
      return (r == 2'd3) ? 2'd2 : r;
   endfunction

   // Driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic idle_inputs();
      Start = 0; Stop = 0; Obstacle = 0; OcA = 0; OcB = 0; FaultClr = 0;
      LfA = 2'd0; LfB = 2'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RSTn = 1'b0;
      tick(2);
      RSTn = 1'b1;
      tick(1);
   endtask

   task automatic enter_run(input logic [1:0] a, input logic [1:0] b);
      LfA = a; LfB = b; Start = 1'b1;
      tick(1);
      Start = 1'b0;
      tick(SETTLE);
   endtask

   task automatic test_reset();
      idle_inputs();
      RSTn = 1'b0;
      tick(2);
      checks++; if (State !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", State, S_IDLE); end
      checks++; if ({DriveA, DriveB} !== 4'b0) begin errors++; $display("FAIL reset_drive: got %0d/%0d want 0/0", DriveA, DriveB); end
      checks++; if (FaultFlag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %0b want 0", FaultFlag); end
      RSTn = 1'b1;
      tick(1);
   endtask

   task automatic test_run();
      logic [1:0] ta [5] = '{2'd3, 2'd1, 2'd0, 2'd3, 2'd2};
      logic [1:0] tb [5] = '{2'd0, 2'd3, 2'd2, 2'd3, 2'd2};
      logic [3:0] exp;
      do_reset();
      LfA = 2'd2; LfB = 2'd1; Start = 1'b1;
      tick(1);
      checks++; if (State !== S_RUN) begin errors++; $display("FAIL run_enter: got %0d want %0d", State, S_RUN); end
      checks++; if ({DriveA, DriveB} !== 4'b0) begin errors++; $display("FAIL run_latency: got %0d/%0d want 0/0", DriveA, DriveB); end
      Start = 1'b0;
      exp_q.push_back({ref_clamp(LfA), ref_clamp(LfB)});
      tick(SETTLE);
      exp = exp_q.pop_front();
      checks++; if ({DriveA, DriveB} !== exp) begin errors++; $display("FAIL run_drive: got %0d/%0d want %0d/%0d", DriveA, DriveB, exp[3:2], exp[1:0]); end
      for (int i = 0; i < 5; i++) begin
         LfA = ta[i]; LfB = tb[i];
         exp_q.push_back({ref_clamp(LfA), ref_clamp(LfB)});
         tick(SETTLE);
         exp = exp_q.pop_front();
         checks++; if ({DriveA, DriveB} !== exp) begin errors++; $display("FAIL run_table[%0d]: got %0d/%0d want %0d/%0d", i, DriveA, DriveB, exp[3:2], exp[1:0]); end
      end
   endtask

   task automatic test_obstacle();
      logic [3:0] exp;
      do_reset();
      enter_run(2'd1, 2'd2);
      Obstacle = 1'b1;
      tick(3);
      Obstacle = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         checks++; if (State !== S_RUN) begin errors++; $display("FAIL obs_glitch[%0d]: got %0d want %0d", i, State, S_RUN); end
      end
      Obstacle = 1'b1;
      tick(4);
      checks++; if (State !== S_RUN) begin errors++; $display("FAIL obs_pre_hold: got %0d want %0d", State, S_RUN); end
      tick(1);
      checks++; if (State !== S_HOLD) begin errors++; $display("FAIL obs_hold: got %0d want %0d", State, S_HOLD); end
      exp_q.push_back(4'b0000);
      tick(SETTLE);
      exp = exp_q.pop_front();
      checks++; if ({DriveA, DriveB} !== exp) begin errors++; $display("FAIL obs_hold_drive: got %0d/%0d want %0d/%0d", DriveA, DriveB, exp[3:2], exp[1:0]); end
      Start = 1'b1;
      tick(1);
      Start = 1'b0;
      checks++; if (State !== S_HOLD) begin errors++; $display("FAIL hold_ignores_start: got %0d want %0d", State, S_HOLD); end
      Obstacle = 1'b0;
      tick(4);
      checks++; if (State !== S_HOLD) begin errors++; $display("FAIL obs_pre_release: got %0d want %0d", State, S_HOLD); end
      tick(1);
      checks++; if (State !== S_RUN) begin errors++; $display("FAIL obs_release: got %0d want %0d", State, S_RUN); end
      exp_q.push_back({ref_clamp(LfA), ref_clamp(LfB)});
      tick(SETTLE);
      exp = exp_q.pop_front();
      checks++; if ({DriveA, DriveB} !== exp) begin errors++; $display("FAIL obs_resume_drive: got %0d/%0d want %0d/%0d", DriveA, DriveB, exp[3:2], exp[1:0]); end
   endtask

   task automatic test_fault();
      int cool_len;
      do_reset();
      enter_run(2'd2, 2'd2);
      checks++; if ({DriveA, DriveB} !== 4'b1010) begin errors++; $display("FAIL fault_pre_drive: got %0d/%0d want 2/2", DriveA, DriveB); end
      OcB = 1'b1;
      tick(1);
      OcB = 1'b0;
      checks++; if (State !== S_FAULT) begin errors++; $display("FAIL fault_enter: got %0d want %0d", State, S_FAULT); end
      checks++; if ({DriveA, DriveB} !== 4'b0) begin errors++; $display("FAIL fault_drive: got %0d/%0d want 0/0", DriveA, DriveB); end
      checks++; if (FaultFlag !== 1'b1) begin errors++; $display("FAIL fault_flag: got %0b want 1", FaultFlag); end
      OcB = 1'b1; FaultClr = 1'b1;
      tick(1);
      checks++; if (State !== S_FAULT) begin errors++; $display("FAIL fault_clr_blocked: got %0d want %0d", State, S_FAULT); end
      OcB = 1'b0;
      tick(1);
      FaultClr = 1'b0;
      checks++; if (State !== S_COOL) begin errors++; $display("FAIL cool_enter: got %0d want %0d", State, S_COOL); end
      checks++; if (FaultFlag !== 1'b1) begin errors++; $display("FAIL cool_flag: got %0b want 1", FaultFlag); end
      cool_len = 1;
      for (int i = 0; i < 4 * COOL_CYCLES; i++) begin
         tick(1);
         if (State == S_COOL) cool_len++;
         else break;
      end
      checks++; if (cool_len != COOL_CYCLES) begin errors++; $display("FAIL cool_length: got %0d want %0d", cool_len, COOL_CYCLES); end
      checks++; if (State !== S_IDLE) begin errors++; $display("FAIL cool_exit: got %0d want %0d", State, S_IDLE); end
      checks++; if (FaultFlag !== 1'b0) begin errors++; $display("FAIL cool_exit_flag: got %0b want 0", FaultFlag); end
   endtask

   task automatic test_cool_abort();
      int cool_len;
      do_reset();
      OcA = 1'b1;
      tick(1);
      OcA = 1'b0;
      checks++; if (State !== S_FAULT) begin errors++; $display("FAIL idle_to_fault: got %0d want %0d", State, S_FAULT); end
      FaultClr = 1'b1;
      tick(1);
      FaultClr = 1'b0;
      tick(4);
      checks++; if (State !== S_COOL) begin errors++; $display("FAIL cool_mid: got %0d want %0d", State, S_COOL); end
      OcA = 1'b1;
      tick(1);
      OcA = 1'b0;
      checks++; if (State !== S_FAULT) begin errors++; $display("FAIL cool_abort: got %0d want %0d", State, S_FAULT); end
      checks++; if (FaultFlag !== 1'b1) begin errors++; $display("FAIL cool_abort_flag: got %0b want 1", FaultFlag); end
      FaultClr = 1'b1;
      tick(1);
      FaultClr = 1'b0;
      cool_len = (State == S_COOL) ? 1 : 0;
      for (int i = 0; i < 4 * COOL_CYCLES; i++) begin
         tick(1);
         if (State == S_COOL) cool_len++;
         else break;
      end
      checks++; if (cool_len != COOL_CYCLES) begin errors++; $display("FAIL cool_restart_length: got %0d want %0d", cool_len, COOL_CYCLES); end
   endtask

   task automatic test_priority();
      do_reset();
      enter_run(2'd2, 2'd2);
      OcA = 1'b1; Stop = 1'b1; Start = 1'b1;
      tick(1);
      checks++; if (State !== S_FAULT) begin errors++; $display("FAIL prio_oc: got %0d want %0d", State, S_FAULT); end
      checks++; if ({DriveA, DriveB} !== 4'b0) begin errors++; $display("FAIL prio_oc_drive: got %0d/%0d want 0/0", DriveA, DriveB); end
      do_reset();
      enter_run(2'd1, 2'd1);
      Obstacle = 1'b1;
      tick(4);
      Stop = 1'b1;
      tick(1);
      checks++; if (State !== S_IDLE) begin errors++; $display("FAIL prio_stop_obs: got %0d want %0d", State, S_IDLE); end
      Stop = 1'b0; Start = 1'b1;
      tick(1);
      checks++; if (State !== S_RUN) begin errors++; $display("FAIL start_held: got %0d want %0d", State, S_RUN); end
      Start = 1'b0;
   endtask

   task automatic test_drive_step();
      do_reset();
      enter_run(2'd0, 2'd0);
      LfA = 2'd2;
`ifdef DRIVE_RAMP_EN
      tick(2);
      checks++; if (DriveA !== 2'd0) begin errors++; $display("FAIL ramp_t2: got %0d want 0", DriveA); end
      tick(1);
      checks++; if (DriveA !== 2'd1) begin errors++; $display("FAIL ramp_t3: got %0d want 1", DriveA); end
      tick(2);
      checks++; if (DriveA !== 2'd1) begin errors++; $display("FAIL ramp_t5: got %0d want 1", DriveA); end
      tick(1);
      checks++; if (DriveA !== 2'd2) begin errors++; $display("FAIL ramp_t6: got %0d want 2", DriveA); end
`else
      tick(1);
      checks++; if (DriveA !== 2'd2) begin errors++; $display("FAIL step_direct: got %0d want 2", DriveA); end
`endif
      OcA = 1'b1;
      tick(1);
      OcA = 1'b0;
      checks++; if (DriveA !== 2'd0) begin errors++; $display("FAIL step_fault_zero: got %0d want 0", DriveA); end
      checks++; if (State !== S_FAULT) begin errors++; $display("FAIL step_fault_state: got %0d want %0d", State, S_FAULT); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      enter_run(2'd2, 2'd2);
      checks++; if ({DriveA, DriveB} !== 4'b1010) begin errors++; $display("FAIL mid_pre_drive: got %0d/%0d want 2/2", DriveA, DriveB); end
      #2;
      RSTn = 1'b0;
      #1;
      checks++; if (State !== S_IDLE) begin errors++; $display("FAIL mid_reset_state: got %0d want %0d", State, S_IDLE); end
      checks++; if ({DriveA, DriveB} !== 4'b0) begin errors++; $display("FAIL mid_reset_drive: got %0d/%0d want 0/0", DriveA, DriveB); end
      checks++; if (FaultFlag !== 1'b0) begin errors++; $display("FAIL mid_reset_flag: got %0b want 0", FaultFlag); end
      @(negedge CLK);
      RSTn = 1'b1;
      tick(3);
      checks++; if (State !== S_IDLE) begin errors++; $display("FAIL mid_stay_idle: got %0d want %0d", State, S_IDLE); end
      Start = 1'b1;
      tick(1);
      Start = 1'b0;
      checks++; if (State !== S_RUN) begin errors++; $display("FAIL mid_restart: got %0d want %0d", State, S_RUN); end
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
      $fatal(1, "watchdog timeout");
   end

   // Test sequence and final report
   initial begin
      checks = 0;
      errors = 0;
      idle_inputs();
      RSTn = 1'b0;
      test_reset();
      test_run();
      test_obstacle();
      test_fault();
      test_cool_abort();
      test_priority();
      test_drive_step();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
